instruction_encoder: RTL

Packs instruction requests (opcode, rd, rs, immediate) into the 8-bit instruction byte stream that the control unit decodes. It is the transmit end of the instruction interface and sits between a program source (test sequencer, loader or future fetch stage) and the control unit's `inst` input. Requests are buffered in a small FIFO. Immediate-form instructions are serialized as two bytes over a valid/ready output handshake.

---
 rtl/instruction_encoder_if.sv | 37 +++
 rtl/instruction_encoder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder_if.sv
// rtl/instruction_encoder_if.sv - request and instruction-byte bus bundle for instruction_encoder
//
// Groups the request handshake (program source -> encoder) and the instruction
// byte stream (encoder -> control unit) into one bundle.
//   master : encoder side (accepts requests, drives the byte stream)
//   slave  : environment side (issues requests, consumes bytes)
// Signals:
//   req_valid/req_ready, req_op[3:0], req_rd[1:0], req_rs[1:0], req_imm[7:0]
//   inst[7:0], inst_valid, inst_ready, inst_first
//   count[$clog2(DEPTH):0]  request FIFO occupancy
interface instruction_encoder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [1:0]    req_rd;
  logic [1:0]    req_rs;
  logic [7:0]    req_imm;
  logic [7:0]    inst;
  logic          inst_valid;
  logic          inst_ready;
  logic          inst_first;
  logic [CW-1:0] count;

  modport master (
    input  req_valid, req_op, req_rd, req_rs, req_imm, inst_ready,
    output req_ready, inst, inst_valid, inst_first, count
  );

  modport slave (
    output req_valid, req_op, req_rd, req_rs, req_imm, inst_ready,
    input  req_ready, inst, inst_valid, inst_first, count
  );
endinterface

// File: rtl/instruction_encoder.sv
// rtl/instruction_encoder.sv - buffers instruction requests and serializes them into instruction bytes
//
// Requests {op, rd, rs, imm} are queued in a DEPTH-entry FIFO, then formatted:
//   LD/ST          : one byte {op, imm[3:0]}
//   register forms : one byte {op, rd, rs}
//   immediate forms: two bytes {op, rd, 2'b00} then imm[7:0]
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset, clears all state
//   bus    instruction_encoder_if.master (request handshake, byte stream, count)
module instruction_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  instruction_encoder_if.master bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OP   = 2'd1,
    IMM  = 2'd2
  } state_t;

  // FIFO entry layout: {op[15:12], rd[11:10], rs[9:8], imm[7:0]}
  logic [15:0]   mem_q [DEPTH];
  logic [15:0]   mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t        state_q, state_d;
  logic [7:0]    inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic          inst_first_q, inst_first_d;
  logic [7:0]    imm_hold_q, imm_hold_d;

  logic          push;
  logic          pop;
  logic          xfer;
  logic          fifo_empty;
  logic [15:0]   head;

  function automatic logic is_imm_op(input logic [3:0] op);
    return (op == 4'b0010) || (op == 4'b1001) || (op == 4'b1011) || (op[3:2] == 2'b11);
  endfunction

  // First (or only) byte of an instruction built from a FIFO entry.
  function automatic logic [7:0] first_byte(input logic [15:0] e);
    logic [3:0] op;
    op = e[15:12];
    if (op[3:1] == 3'b000)    return {op, e[3:0]};          // LD, ST
    else if (is_imm_op(op))   return {op, e[11:10], 2'b00}; // immediate form byte0
    else                      return {op, e[11:10], e[9:8]};
  endfunction

  assign bus.req_ready  = (count_q != CW'(DEPTH));
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_first = inst_first_q;
  assign bus.count      = count_q;

  assign push       = bus.req_valid & bus.req_ready;
  assign xfer       = inst_valid_q & bus.inst_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    state_d      = state_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_first_d = inst_first_q;
    imm_hold_d   = imm_hold_q;
    pop          = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.req_op, bus.req_rd, bus.req_rs, bus.req_imm};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    case (state_q)
      IDLE: begin
        if (!fifo_empty) pop = 1'b1;
      end
      OP: begin
        if (xfer) begin
          // inst_q holds byte0 here, so its upper nibble is the opcode.
          if (is_imm_op(inst_q[7:4])) begin
            state_d      = IMM;
            inst_d       = imm_hold_q;
            inst_first_d = 1'b0;
          end else if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d      = IDLE;
            inst_d       = 8'h00;
            inst_valid_d = 1'b0;
            inst_first_d = 1'b0;
          end
        end
      end
      IMM: begin
        if (xfer) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            state_d      = IDLE;
            inst_d       = 8'h00;
            inst_valid_d = 1'b0;
            inst_first_d = 1'b0;
          end
        end
      end
      default: begin
        state_d      = IDLE;
        inst_d       = 8'h00;
        inst_valid_d = 1'b0;
        inst_first_d = 1'b0;
      end
    endcase

    // Pop loads the output stage straight from the FIFO head; the immediate
    // is parked so byte1 can follow without touching the FIFO again.
    if (pop) begin
      state_d      = OP;
      inst_d       = first_byte(head);
      inst_valid_d = 1'b1;
      inst_first_d = 1'b1;
      imm_hold_d   = head[7:0];
      rd_ptr_d     = rd_ptr_q + AW'(1);
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      inst_q       <= 8'h00;
      inst_valid_q <= 1'b0;
      inst_first_q <= 1'b0;
      imm_hold_q   <= 8'h00;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_first_q <= inst_first_d;
      imm_hold_q   <= imm_hold_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule
